// File: rtl/cross_patterns_scan.sv
// Finder-pattern cross stage: scans per-row and per-column flag vectors,
// merges gap-tolerant runs of flagged lines and reports each accepted
// run's midpoint as a finder-center coordinate for that axis.
module cross_patterns_scan #(
    parameter int unsigned DIM         = 480,
    parameter int unsigned COORD_W     = 9,
    parameter int unsigned NUM_CENTERS = 3,
    parameter int unsigned MIN_RUN     = 3,
    parameter int unsigned GAP_TOL     = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [DIM-1:0]                 horz_patterns,
    input  logic [DIM-1:0]                 vert_patterns,
    input  logic                           start_cross,
    input  logic [2*COORD_W-1:0]           win_x,
    input  logic [2*COORD_W-1:0]           win_y,
    output logic                           busy,
    output logic [NUM_CENTERS*COORD_W-1:0] centers_x,
    output logic [NUM_CENTERS*COORD_W-1:0] centers_y,
    output logic [COORD_W-1:0]             count_x,
    output logic [COORD_W-1:0]             count_y,
    output logic                           centers_valid,
    output logic                           centers_not_found_error
);

    localparam logic [COORD_W-1:0] LastIdx    = COORD_W'(DIM - 1);
    localparam logic [COORD_W-1:0] GapTol     = COORD_W'(GAP_TOL);
    localparam logic [COORD_W-1:0] NumCenters = COORD_W'(NUM_CENTERS);
    localparam logic [COORD_W-1:0] OneW       = COORD_W'(1);
    localparam logic [COORD_W:0]   MinRun     = (COORD_W + 1)'(MIN_RUN);
    localparam logic [COORD_W:0]   OneW1      = (COORD_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] idx_q;
    logic               start_go;

    assign start_go = (state_q == StIdle) && start_cross;
    assign busy     = (state_q != StIdle);

    // Next-state decode for the scan sequencer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_cross) state_d = StScan;
            StScan:  if (idx_q == LastIdx) state_d = StFlush;
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state, line index and the completion pulses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q                 <= StIdle;
            idx_q                   <= '0;
            centers_valid           <= 1'b0;
            centers_not_found_error <= 1'b0;
        end else begin
            state_q                 <= state_d;
            centers_valid           <= 1'b0;
            centers_not_found_error <= 1'b0;
            if (start_go) begin
                idx_q <= '0;
            end else if (state_q == StScan && idx_q != LastIdx) begin
                idx_q <= idx_q + OneW;
            end
            if (state_q == StDone) begin
                if (g_axis[0].count_q == NumCenters && g_axis[1].count_q == NumCenters) begin
                    centers_valid <= 1'b1;
                end else begin
                    centers_not_found_error <= 1'b1;
                end
            end
        end
    end

    // Axis 0 scans rows (horz_patterns / win_y), axis 1 scans columns.
    for (genvar a = 0; a < 2; a++) begin : g_axis
        logic [DIM-1:0]                 pat_in, pat_q;
        logic [2*COORD_W-1:0]           win_in;
        logic [COORD_W-1:0]             lo_in, hi_in, lo_q, hi_q;
        logic                           run_open_q;
        logic [COORD_W-1:0]             run_start_q, run_last_q, gap_q, count_q;
        logic [NUM_CENTERS*COORD_W-1:0] centers_q;
        logic                           bit_on, run_close, run_accept;
        logic [COORD_W:0]               run_len, center_sum;

        assign pat_in = (a == 0) ? horz_patterns : vert_patterns;
        assign win_in = (a == 0) ? win_y : win_x;
        // Window bounds beyond the last line are pulled back onto it
        assign lo_in  = (win_in[COORD_W-1:0] > LastIdx) ? LastIdx : win_in[COORD_W-1:0];
        assign hi_in  = (win_in[2*COORD_W-1:COORD_W] > LastIdx) ?
                        LastIdx : win_in[2*COORD_W-1:COORD_W];

        // Windowed bit, run-close and acceptance decisions for this cycle
        always_comb begin
            bit_on = 1'b0;
            if (state_q == StScan) begin
                bit_on = pat_q[idx_q] && (idx_q >= lo_q) && (idx_q <= hi_q);
            end
            // A run closes on its (GAP_TOL+1)-th consecutive 0, or at the end of the vector
            run_close  = run_open_q && ((state_q == StFlush) ||
                         (state_q == StScan && !bit_on && gap_q == GapTol));
            run_len    = {1'b0, run_last_q} - {1'b0, run_start_q} + OneW1;
            center_sum = {1'b0, run_start_q} + {1'b0, run_last_q};
            run_accept = run_close && (run_len >= MinRun);
        end

        // Latch inputs on start, then track runs and record accepted centers
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                pat_q       <= '0;
                lo_q        <= '0;
                hi_q        <= '0;
                run_open_q  <= 1'b0;
                run_start_q <= '0;
                run_last_q  <= '0;
                gap_q       <= '0;
                count_q     <= '0;
                centers_q   <= '0;
            end else if (start_go) begin
                pat_q       <= pat_in;
                lo_q        <= lo_in;
                hi_q        <= hi_in;
                run_open_q  <= 1'b0;
                run_start_q <= '0;
                run_last_q  <= '0;
                gap_q       <= '0;
                count_q     <= '0;
                centers_q   <= '0;
            end else begin
                if (bit_on) begin
                    run_open_q <= 1'b1;
                    if (!run_open_q) run_start_q <= idx_q;
                    run_last_q <= idx_q;
                    gap_q      <= '0;
                end else if (run_close) begin
                    run_open_q <= 1'b0;
                    gap_q      <= '0;
                end else if (run_open_q && state_q == StScan) begin
                    gap_q <= gap_q + OneW;
                end
                if (run_accept) begin
                    // Runs past the last slot are counted but not stored
                    for (int k = 0; k < int'(NUM_CENTERS); k++) begin
                        if (count_q == COORD_W'(k)) begin
                            centers_q[k*COORD_W +: COORD_W] <= center_sum[COORD_W:1];
                        end
                    end
                    if (count_q != '1) count_q <= count_q + OneW;
                end
            end
        end
    end

    assign centers_y = g_axis[0].centers_q;
    assign count_y   = g_axis[0].count_q;
    assign centers_x = g_axis[1].centers_q;
    assign count_x   = g_axis[1].count_q;

endmodule
